// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: round-robin arbiter that shares one SDRAM controller
// command port between a single-word write port (W) and a page-read port (R).
//
// Ports:
//   clk, rst                   100 MHz SDRAM clock, synchronous active-high reset
//   w_req/w_addr/w_data/w_ack  write requester (level req, 1-cycle ack pulse)
//   r_req/r_addr               page-read requester (level req)
//   r_valid/r_data/r_ack       forwarded read words and 1-cycle completion pulse
//   sd_call/sd_done            controller call/done vectors (bit1 = W, bit2 = R)
//   sd_addr/sd_wdata           frozen address/data for the active call
//   sd_en/sd_rdata             controller read-data strobe and word
//   err                        sticky watchdog flag
//   busy                       high whenever the arbiter is not IDLE
module sdram_req_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ack,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              r_ack,
  output logic [2:0]        sd_call,
  input  logic [2:0]        sd_done,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_en,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] CALL_WR = 3'b010;
  localparam logic [2:0] CALL_RD = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    CALL_W,
    CALL_R,
    RELEASE
  } state_t;

  state_t           state;
  logic             last_w;
  logic [CNT_W-1:0] cnt;

  logic grant_w;
  logic grant_r;
  logic done_w;
  logic done_r;
  logic timeout;

  // Bit 0 of the done vector belongs to a port this arbiter never calls.
  logic unused_done0;
  assign unused_done0 = sd_done[0];

  // On a tie, the port that was not granted last wins.
  always_comb begin
    grant_w = w_req && (!r_req || !last_w);
    grant_r = r_req && !grant_w;
  end

  assign done_w  = sd_done[1];
  assign done_r  = sd_done[2];
  assign timeout = (cnt == CNT_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_w   <= 1'b0;
      cnt      <= '0;
      sd_call  <= 3'b000;
      sd_addr  <= '0;
      sd_wdata <= '0;
      w_ack    <= 1'b0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      err      <= 1'b0;
    end else begin
      w_ack   <= 1'b0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_w) begin
            sd_addr  <= w_addr;
            sd_wdata <= w_data;
            sd_call  <= CALL_WR;
            last_w   <= 1'b1;
            cnt      <= '0;
            state    <= CALL_W;
          end else if (grant_r) begin
            sd_addr <= r_addr;
            sd_call <= CALL_RD;
            last_w  <= 1'b0;
            cnt     <= '0;
            state   <= CALL_R;
          end
        end
        CALL_W: begin
          // A done in the timeout cycle still counts as a clean finish.
          if (done_w || timeout) begin
            sd_call <= 3'b000;
            w_ack   <= 1'b1;
            if (!done_w) err <= 1'b1;
            state   <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CALL_R: begin
          // A strobe coincident with done lands together with r_ack.
          r_valid <= sd_en;
          if (sd_en) r_data <= sd_rdata;
          if (done_r || timeout) begin
            sd_call <= 3'b000;
            r_ack   <= 1'b1;
            if (!done_r) err <= 1'b1;
            state   <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_call_onehot: assert property (
    @(posedge clk) disable iff (rst) !(sd_call[1] && sd_call[2]));
  a_call_bit0: assert property (
    @(posedge clk) disable iff (rst) !sd_call[0]);

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed self-checking bench for sdram_req_arbiter.
// A second instance with TIMEOUT=16 exercises the watchdog.
module tb_sdram_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_req = 1'b0;
  logic [23:0] w_addr = '0;
  logic [15:0] w_data = '0;
  logic        r_req = 1'b0;
  logic [23:0] r_addr = '0;
  logic [2:0]  sd_done = '0;
  logic        sd_en = 1'b0;
  logic [15:0] sd_rdata = '0;

  logic        w_ack, r_valid, r_ack, err, busy;
  logic [15:0] r_data, sd_wdata;
  logic [2:0]  sd_call;
  logic [23:0] sd_addr;

  logic        wd_w_ack, wd_r_valid, wd_r_ack, wd_err, wd_busy;
  logic [15:0] wd_r_data, wd_sd_wdata;
  logic [2:0]  wd_sd_call;
  logic [23:0] wd_sd_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
    .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid),
    .r_data(r_data), .r_ack(r_ack),
    .sd_call(sd_call), .sd_done(sd_done), .sd_addr(sd_addr),
    .sd_wdata(sd_wdata), .sd_en(sd_en), .sd_rdata(sd_rdata),
    .err(err), .busy(busy)
  );

  sdram_req_arbiter #(.TIMEOUT(16)) dut_wd (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(wd_w_ack),
    .r_req(r_req), .r_addr(r_addr), .r_valid(wd_r_valid),
    .r_data(wd_r_data), .r_ack(wd_r_ack),
    .sd_call(wd_sd_call), .sd_done(sd_done), .sd_addr(wd_sd_addr),
    .sd_wdata(wd_sd_wdata), .sd_en(sd_en), .sd_rdata(sd_rdata),
    .err(wd_err), .busy(wd_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int acks;
    logic [2:0] exp_call;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_call", sd_call, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_wack", w_ack, 0);
    chk("rst_rack", r_ack, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_addr", sd_addr, 0);

    // single write, done 3 cycles after call
    w_req = 1'b1; w_addr = 24'h000005; w_data = 16'h00A5;
    tick();
    chk("wr_call0", sd_call, 3'b010);
    chk("wr_busy", busy, 1);
    w_addr = 24'h000007; w_data = 16'h1111;
    tick();
    chk("wr_call1", sd_call, 3'b010);
    tick();
    chk("wr_call2", sd_call, 3'b010);
    chk("wr_addr", sd_addr, 24'h000005);
    chk("wr_data", sd_wdata, 16'h00A5);
    sd_done = 3'b010;
    tick();
    sd_done = 3'b000;
    chk("wr_drop", sd_call, 0);
    chk("wr_ack", w_ack, 1);
    w_req = 1'b0;
    tick();
    chk("wr_ack_pulse", w_ack, 0);
    chk("wr_rel_call", sd_call, 0);
    chk("wr_idle_busy", busy, 0);
    tick();
    chk("wr_idle_call", sd_call, 0);

    // page read of 512 words, last strobe coincident with done
    r_req = 1'b1; r_addr = 24'h000000;
    tick();
    chk("rd_call", sd_call, 3'b100);
    chk("rd_addr", sd_addr, 0);
    for (int i = 0; i < 512; i++) begin
      sd_en = 1'b1;
      sd_rdata = 16'(i);
      if (i == 511) sd_done = 3'b100;
      tick();
      chk("rd_valid", r_valid, 1);
      chk("rd_data", r_data, i);
      if (i < 511) chk("rd_noack", r_ack, 0);
    end
    sd_en = 1'b0; sd_done = 3'b000; r_req = 1'b0;
    chk("rd_ack", r_ack, 1);
    chk("rd_drop", sd_call, 0);
    chk("rd_err", err, 0);
    tick();
    chk("rd_ack_pulse", r_ack, 0);
    chk("rd_valid_end", r_valid, 0);
    tick();

    // stray inputs
    sd_en = 1'b1; sd_rdata = 16'hBEEF;
    tick();
    chk("stray_en_idle", r_valid, 0);
    sd_en = 1'b0;
    w_req = 1'b1; w_addr = 24'h000009; w_data = 16'h1234;
    tick();
    chk("stray_call", sd_call, 3'b010);
    sd_done = 3'b100;
    tick();
    sd_done = 3'b000;
    chk("stray_hold", sd_call, 3'b010);
    chk("stray_rack", r_ack, 0);
    chk("stray_wack", w_ack, 0);
    sd_en = 1'b1;
    tick();
    sd_en = 1'b0;
    chk("stray_en_w", r_valid, 0);
    sd_done = 3'b010;
    tick();
    sd_done = 3'b000;
    chk("stray_wdone", w_ack, 1);
    chk("stray_wdrop", sd_call, 0);
    chk("stray_rack2", r_ack, 0);
    w_req = 1'b0;
    tick();
    tick();

    // contention from reset: W, R, W, R
    rst = 1'b1; w_req = 1'b1; r_req = 1'b1;
    w_addr = 24'h000100; r_addr = 24'h000200;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_call = (k % 2 == 0) ? 3'b010 : 3'b100;
      n = 0;
      while (sd_call == 3'b000 && n < 8) begin
        tick();
        n++;
      end
      chk("cont_wait", (n < 8), 1);
      chk("cont_grant", sd_call, exp_call);
      chk("cont_excl", sd_call[1] & sd_call[2], 0);
      sd_done = sd_call;
      tick();
      sd_done = 3'b000;
      chk("cont_ack", {w_ack, r_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 3) begin
        w_req = 1'b0; r_req = 1'b0;
      end
    end
    tick();
    tick();
    chk("cont_idle", sd_call, 0);

    // watchdog on the TIMEOUT=16 instance
    do_reset();
    w_req = 1'b1; w_addr = 24'h000003; w_data = 16'h0055;
    tick();
    chk("wd_call", wd_sd_call, 3'b010);
    n = 1;
    acks = 0;
    while (wd_sd_call != 3'b000 && n < 40) begin
      tick();
      if (wd_w_ack) acks++;
      if (wd_sd_call != 3'b000) n++;
    end
    w_req = 1'b0;
    chk("wd_cycles", n, 16);
    chk("wd_err", wd_err, 1);
    chk("wd_ack", wd_w_ack, 1);
    tick();
    if (wd_w_ack) acks++;
    chk("wd_ack_once", acks, 1);
    chk("wd_err_sticky", wd_err, 1);
    r_req = 1'b1; r_addr = 24'h000040;
    tick();
    tick();
    chk("wd_rd_call", wd_sd_call, 3'b100);
    chk("wd_rd_addr", wd_sd_addr, 24'h000040);
    sd_done = 3'b100;
    tick();
    sd_done = 3'b000;
    r_req = 1'b0;
    chk("wd_rd_ack", wd_r_ack, 1);
    chk("wd_err_hold", wd_err, 1);
    tick();
    tick();

    // reset in the middle of a page read
    do_reset();
    r_req = 1'b1; r_addr = 24'h000100;
    tick();
    chk("mr_call", sd_call, 3'b100);
    for (int i = 0; i < 10; i++) begin
      sd_en = 1'b1;
      sd_rdata = 16'(i + 1);
      tick();
    end
    sd_en = 1'b0;
    chk("mr_data", r_data, 10);
    rst = 1'b1; r_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("mr_call0", sd_call, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rack", r_ack, 0);
    chk("mr_rvalid", r_valid, 0);
    tick();
    chk("mr_noack", r_ack, 0);
    r_req = 1'b1; r_addr = 24'h000200;
    tick();
    chk("mr_regrant", sd_call, 3'b100);
    chk("mr_addr", sd_addr, 24'h000200);
    sd_done = 3'b100;
    tick();
    sd_done = 3'b000;
    r_req = 1'b0;
    chk("mr_ack", r_ack, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single SDRAM controller command port (call/done/addr/data handshake) between two requesters:
  - Write port W: single-word writes, e.g. camera pixel writer.
  - Read port R: page reads, e.g. display line fetch.
- Grants round-robin, holds the controller call line until done, and forwards the address, write data and read-data strobes.
- A watchdog aborts any call that never completes and raises an error flag.
- Sits between the frame writer/reader logic and the SDRAM top module, in the 100 MHz SDRAM clock domain.

Parameters:
- ADDR_W, 24, width of the SDRAM word address.
- DATA_W, 16, SDRAM data width.
- TIMEOUT, 4096, maximum cycles a call may stay asserted without done; must be >= 2.

Ports:
- clk  in  1  SDRAM-domain clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- w_req  in  1  write request; level, held until w_ack.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- w_ack  out  1  one-cycle pulse: write completed.
- r_req  in  1  page-read request; level, held until r_ack.
- r_addr  in  ADDR_W  page start address.
- r_valid  out  1  read word strobe, forwarded from sd_en during an R grant.
- r_data  out  DATA_W  read word, forwarded from sd_rdata.
- r_ack  out  1  one-cycle pulse: page read completed.
- sd_call  out  3  controller call vector: bit1 = write, bit2 = page read, bit0 always 0.
- sd_done  in  3  controller done vector; one-cycle pulses.
- sd_addr  out  ADDR_W  address to controller (also drives iAddrPage).
- sd_wdata  out  DATA_W  write data to controller.
- sd_en  in  1  controller read-data strobe.
- sd_rdata  in  DATA_W  controller read data.
- err  out  1  sticky watchdog flag; cleared only by rst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last-grant pointer = R, so W wins the first tie.
- States: IDLE, CALL_W, CALL_R, RELEASE.
- IDLE:
  - Only w_req: latch w_addr/w_data into sd_addr/sd_wdata, go to CALL_W.
  - Only r_req: latch r_addr into sd_addr, go to CALL_R.
  - Both: grant the port not granted last, then update the pointer.
  - sd_call becomes non-zero in the cycle after the request is sampled; arbitration latency is 1 cycle.
- CALL_W:
  - sd_call = 3'b010.
  - sd_addr/sd_wdata stay frozen; later changes on w_addr/w_data are ignored.
  - sd_done[1] = 1: sd_call <= 0, w_ack pulses 1 cycle (same edge), go to RELEASE.
- CALL_R:
  - sd_call = 3'b100.
  - Each cycle, r_valid = sd_en and r_data = sd_rdata, registered with 1-cycle latency.
  - sd_done[2] = 1: sd_call <= 0, r_ack pulses, go to RELEASE.
  - The final r_valid, if coincident with done, is still delivered before or with r_ack.
- RELEASE:
  - One mandatory cycle with sd_call = 0, so the controller sees the call drop; then IDLE.
  - Back-to-back transactions are therefore separated by >= 2 cycles of sd_call low (RELEASE + IDLE).
- Requester rules:
  - A requester must hold req high until its ack.
  - Dropping req mid-call has no effect; the call runs to done and the ack still pulses.
  - req still high in the cycle after its ack is treated as a new request.
- Outside grants:
  - sd_done bits that do not match the current grant, or arrive in IDLE/RELEASE, are ignored.
  - sd_en outside CALL_R is ignored (r_valid = 0).
- Watchdog:
  - A counter resets on entering CALL_W/CALL_R and increments while in them.
  - Reaching TIMEOUT-1 without the matching done: sd_call <= 0, err <= 1, ack pulses anyway (so requesters never hang), go to RELEASE.
  - A matching done and the timeout in the same cycle: the done wins, err is unchanged.
- Fairness: the pointer updates only on a grant, so with both requesting continuously, grants alternate W, R, W, R.
- Reset mid-operation: rst has priority in every state. Next cycle sd_call = 0 and all acks/strobes = 0; no ack is issued for the aborted transaction.

Test Plan:
- Single write: w_req=1, w_addr=24'h000005, w_data=16'h00A5; sd_done[1] pulsed 3 cycles after sd_call=010 -> sd_call=010 exactly 3 cycles, sd_addr=5 and sd_wdata=A5 throughout, one w_ack, then sd_call=0 for >= 2 cycles.
- Page read: r_req=1, r_addr=0; controller gives 512 sd_en strobes with data 0..511, then sd_done[2] -> 512 r_valid with r_data 0..511 in order, one r_ack, err=0.
- Contention: w_req and r_req both held high from reset, 4 transactions -> grant order W, R, W, R; never both sd_call[1] and sd_call[2] high.
- Stray inputs: sd_done[2] pulsed during CALL_W, and sd_en during IDLE -> ignored; no r_ack, no r_valid; write finishes only on sd_done[1].
- Watchdog: TIMEOUT=16, w_req with no sd_done -> sd_call drops after 16 cycles, err=1 (sticky), w_ack pulses once; a following r_req is still served normally.
- Reset mid-read: rst=1 for 1 cycle during CALL_R after 10 strobes -> next cycle sd_call=0, busy=0, no r_ack; a fresh r_req is then granted normally.
